// File: rtl/acc_dispatch_mux.sv
`default_nettype none
// ============================================================================
//  Module      : acc_dispatch_mux
//  Description : Offload dispatcher. Routes each request to one of NUM_ACC
//                accelerator channels using a one-hot select. It records the
//                destination in an order FIFO and returns results to the
//                core in issue order. A zero-hot or multi-hot select produces
//                an error response instead of a dispatch.
//                Optional macro ACC_DISPATCH_RSP_REG_EN registers the
//                response path through a 2-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_dispatch_mux #(
  parameter int NUM_ACC         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_RS          = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [31:0]                          req_instr_i,
  input  logic [NUM_RS*DATA_WIDTH-1:0]         req_rs_i,
  input  logic [NUM_ACC-1:0]                   req_sel_i,
  output logic [NUM_ACC-1:0]                   acc_q_valid_o,
  input  logic [NUM_ACC-1:0]                   acc_q_ready_i,
  output logic [31:0]                          acc_q_instr_o,
  output logic [NUM_RS*DATA_WIDTH-1:0]         acc_q_rs_o,
  input  logic [NUM_ACC-1:0]                   acc_p_valid_i,
  output logic [NUM_ACC-1:0]                   acc_p_ready_o,
  input  logic [NUM_ACC*5-1:0]                 acc_p_rd_i,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]        acc_p_data_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [4:0]                           rsp_rd_o,
  output logic [DATA_WIDTH-1:0]                rsp_data_o,
  output logic                                 rsp_error_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int c_IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [3:0]            w_sel_cnt;
  logic [c_IDX_W-1:0]    w_sel_idx;
  logic                  w_sel_ok;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sink_ready;

  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_fifo_err [MAX_OUTSTANDING];
  logic [c_IDX_W-1:0]    r_fifo_idx [MAX_OUTSTANDING];
  logic [4:0]            r_fifo_rd  [MAX_OUTSTANDING];

  logic                  w_head_err;
  logic [c_IDX_W-1:0]    w_head_idx;
  logic                  w_ch_valid;
  logic [4:0]            w_ch_rd;
  logic [DATA_WIDTH-1:0] w_ch_data;
  logic                  w_head_valid;
  logic [4:0]            w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Predecode: count hot select bits and remember the (last) hot index
  always_comb begin
    w_sel_cnt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (req_sel_i[i]) begin
        w_sel_cnt = w_sel_cnt + 4'd1;
        w_sel_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_sel_ok = (w_sel_cnt == 4'd1);
  assign w_full   = (r_count == c_CNT_W'(MAX_OUTSTANDING));
  assign w_empty  = (r_count == '0);

  // Channel valid ignores the channel's own ready; error requests drive nothing
  assign acc_q_valid_o = (req_valid_i & w_sel_ok & ~w_full) ? req_sel_i : '0;
  assign acc_q_instr_o = req_valid_i ? req_instr_i : '0;
  assign acc_q_rs_o    = req_valid_i ? req_rs_i : '0;

  // Illegal selects are accepted locally so they can return an error in order
  assign w_push      = req_valid_i & ~w_full &
                       (w_sel_ok ? |(acc_q_ready_i & req_sel_i) : 1'b1);
  assign req_ready_o = w_push;

  assign w_head_err = r_fifo_err[r_rd_ptr];
  assign w_head_idx = r_fifo_idx[r_rd_ptr];

  // Order FIFO storage: records the destination of every accepted request
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_err[r_wr_ptr] <= ~w_sel_ok;
      r_fifo_idx[r_wr_ptr] <= w_sel_idx;
      r_fifo_rd[r_wr_ptr]  <= req_instr_i[11:7];
    end
  end

  // Order FIFO pointers and occupancy; full blocks push even if a pop occurs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding_o = r_count;

  // Select the head channel's result and grant it; other channels stall
  always_comb begin
    w_ch_valid    = 1'b0;
    w_ch_rd       = '0;
    w_ch_data     = '0;
    acc_p_ready_o = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (c_IDX_W'(i) == w_head_idx) begin
        w_ch_valid = acc_p_valid_i[i];
        w_ch_rd    = acc_p_rd_i[i*5 +: 5];
        w_ch_data  = acc_p_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        if (!w_empty && !w_head_err) acc_p_ready_o[i] = w_sink_ready;
      end
    end
  end

  assign w_head_valid = ~w_empty & (w_head_err | w_ch_valid);
  assign w_head_rd    = w_empty ? 5'd0 : (w_head_err ? r_fifo_rd[r_rd_ptr] : w_ch_rd);
  assign w_head_data  = (w_empty | w_head_err) ? '0 : w_ch_data;
  assign w_pop        = w_head_valid & w_sink_ready;

`ifdef ACC_DISPATCH_RSP_REG_EN
  logic                  r_buf_err  [2];
  logic [4:0]            r_buf_rd   [2];
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic                  r_buf_wp;
  logic                  r_buf_rp;
  logic [1:0]            r_buf_cnt;
  logic                  w_buf_pop;

  // Accepting while either slot is free keeps one transfer per cycle
  assign w_sink_ready = (r_buf_cnt != 2'd2);
  assign w_buf_pop    = (r_buf_cnt != 2'd0) & rsp_ready_i;

  // Skid buffer data slots
  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_buf_err[r_buf_wp]  <= ~w_empty & w_head_err;
      r_buf_rd[r_buf_wp]   <= w_head_rd;
      r_buf_data[r_buf_wp] <= w_head_data;
    end
  end

  // Skid buffer pointers and fill level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_buf_wp  <= 1'b0;
      r_buf_rp  <= 1'b0;
      r_buf_cnt <= 2'd0;
    end else begin
      if (w_pop)     r_buf_wp <= ~r_buf_wp;
      if (w_buf_pop) r_buf_rp <= ~r_buf_rp;
      case ({w_pop, w_buf_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  assign rsp_valid_o = (r_buf_cnt != 2'd0);
  assign rsp_error_o = rsp_valid_o & r_buf_err[r_buf_rp];
  assign rsp_rd_o    = rsp_valid_o ? r_buf_rd[r_buf_rp] : 5'd0;
  assign rsp_data_o  = rsp_valid_o ? r_buf_data[r_buf_rp] : '0;
`else
  assign w_sink_ready = rsp_ready_i;
  assign rsp_valid_o  = w_head_valid;
  assign rsp_error_o  = ~w_empty & w_head_err;
  assign rsp_rd_o     = w_head_rd;
  assign rsp_data_o   = w_head_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acc_dispatch_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_dispatch_mux
//  Description : Self-checking bench for acc_dispatch_mux (default build).
//                Table vectors, directed sequences and a randomized run
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_dispatch_mux;

  localparam int NA = 2;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_instr;
  logic [NR*DW-1:0]  req_rs;
  logic [NA-1:0]     req_sel;
  logic [NA-1:0]     q_valid;
  logic [NA-1:0]     q_ready;
  logic [31:0]       q_instr;
  logic [NR*DW-1:0]  q_rs;
  logic [NA-1:0]     p_valid;
  logic [NA-1:0]     p_ready;
  logic [NA*5-1:0]   p_rd;
  logic [NA*DW-1:0]  p_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [4:0]        rsp_rd;
  logic [DW-1:0]     rsp_data;
  logic              rsp_error;
  logic [2:0]        outstanding;

  int n_pass  = 0;
  int n_total = 0;

  acc_dispatch_mux #(
    .NUM_ACC(NA), .DATA_WIDTH(DW), .NUM_RS(NR), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_rs_i(req_rs), .req_sel_i(req_sel),
    .acc_q_valid_o(q_valid), .acc_q_ready_i(q_ready),
    .acc_q_instr_o(q_instr), .acc_q_rs_o(q_rs),
    .acc_p_valid_i(p_valid), .acc_p_ready_o(p_ready),
    .acc_p_rd_i(p_rd), .acc_p_data_i(p_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rd_o(rsp_rd), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
    .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [1:0] qr;
    logic [1:0] exp_qv;
    logic       exp_rdy;
  } vec_t;

  typedef struct {
    bit       err;
    int       idx;
    bit [4:0] rd;
  } ent_t;

  ent_t mq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_sel = '0; req_instr = '0; req_rs = '0; q_ready = '0;
    p_valid = '0; p_rd = '0; p_data = '0; rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [4:0] rd);
    req_valid = 1'b1;
    req_sel   = sel;
    req_instr = {20'h0, rd, 7'h0b};
    q_ready   = sel;
    tick();
    req_valid = 1'b0; req_sel = '0; q_ready = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[1] = '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1};
    tbl[2] = '{1'b1, 2'b01, 2'b10, 2'b01, 1'b0};
    tbl[3] = '{1'b1, 2'b10, 2'b10, 2'b10, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 2'b00, 2'b10, 1'b0};
    tbl[5] = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b1};
    tbl[6] = '{1'b0, 2'b10, 2'b11, 2'b00, 1'b0};
    tbl[7] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    do_reset();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_instr", q_instr, 0);
    check("rst_q_rs", q_rs, 0);
    check("rst_p_ready", p_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rd", rsp_rd, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_outstanding", outstanding, 0);

    // ---------------- table: request decode with empty FIFO ----------------
    for (int i = 0; i < 8; i++) begin
      tick();
      req_valid = tbl[i].v;
      req_sel   = tbl[i].sel;
      q_ready   = tbl[i].qr;
      req_instr = 32'h1234_5000 + i;
      #1;
      check("tbl_q_valid", q_valid, tbl[i].exp_qv);
      check("tbl_req_ready", req_ready, tbl[i].exp_rdy);
      check("tbl_q_instr", q_instr, tbl[i].v ? 32'h1234_5000 + i : 32'h0);
      req_valid = 1'b0;
    end
    idle();
    tick();
    check("tbl_outstanding", outstanding, 0);

    // ---------------- basic dispatch ----------------
    do_reset();
    req_valid = 1'b1; req_sel = 2'b10; q_ready = 2'b10; req_instr = {20'h0, 5'd5, 7'h0b};
    #1;
    check("basic_q_valid", q_valid, 2'b10);
    check("basic_req_ready", req_ready, 1);
    tick();
    idle();
    p_valid = 2'b10; p_rd = {5'd5, 5'd0}; p_data = {32'hDEADBEEF, 32'h0}; rsp_ready = 1'b1;
    #1;
    check("basic_rsp_valid", rsp_valid, 1);
    check("basic_rsp_rd", rsp_rd, 5);
    check("basic_rsp_data", rsp_data, 32'hDEADBEEF);
    check("basic_rsp_error", rsp_error, 0);
    check("basic_p_ready", p_ready, 2'b10);
    tick();
    idle();
    #1;
    check("basic_outstanding", outstanding, 0);

    // ---------------- in-order return ----------------
    do_reset();
    push(2'b01, 5'd1);
    push(2'b10, 5'd2);
    p_valid = 2'b10; p_rd = {5'd2, 5'd1}; p_data = {32'hBBBB_0002, 32'hAAAA_0001}; rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("order_wait_valid", rsp_valid, 0);
      check("order_wait_p_ready", p_ready, 2'b01);
      tick();
    end
    p_valid = 2'b11;
    #1;
    check("order_first_valid", rsp_valid, 1);
    check("order_first_data", rsp_data, 32'hAAAA_0001);
    check("order_first_p_ready", p_ready, 2'b01);
    tick();
    p_valid = 2'b10;
    #1;
    check("order_second_data", rsp_data, 32'hBBBB_0002);
    check("order_second_rd", rsp_rd, 2);
    check("order_second_p_ready", p_ready, 2'b10);
    tick();
    idle();
    #1;
    check("order_outstanding", outstanding, 0);

    // ---------------- illegal select ----------------
    do_reset();
    req_valid = 1'b1; req_sel = 2'b00; q_ready = 2'b11; req_instr = {20'h0, 5'd9, 7'h0b};
    #1;
    check("ill0_q_valid", q_valid, 0);
    check("ill0_req_ready", req_ready, 1);
    tick();
    req_sel = 2'b11;
    #1;
    check("ill1_q_valid", q_valid, 0);
    check("ill_err_visible", rsp_error, 1);
    tick();
    idle();
    rsp_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      #1;
      check("ill_rsp_valid", rsp_valid, 1);
      check("ill_rsp_error", rsp_error, 1);
      check("ill_rsp_rd", rsp_rd, 9);
      check("ill_rsp_data", rsp_data, 0);
      check("ill_p_ready", p_ready, 0);
      tick();
    end
    #1;
    check("ill_drained", outstanding, 0);

    // ---------------- full boundary ----------------
    do_reset();
    for (int i = 0; i < 4; i++) push(2'b01, 5'(i + 1));
    req_valid = 1'b1; req_sel = 2'b01; q_ready = 2'b01; req_instr = {20'h0, 5'd7, 7'h0b};
    #1;
    check("full_outstanding", outstanding, 4);
    check("full_req_ready", req_ready, 0);
    check("full_q_valid", q_valid, 0);
    tick();
    p_valid = 2'b01; p_data = {32'h0, 32'h0000_1111}; rsp_ready = 1'b1;
    #1;
    check("full_pop_valid", rsp_valid, 1);
    check("full_no_bypass", req_ready, 0);
    tick();
    p_valid = '0; rsp_ready = 1'b0;
    #1;
    check("full_after_pop", outstanding, 3);
    check("full_fifth_ready", req_ready, 1);
    tick();
    idle();
    #1;
    check("full_refilled", outstanding, 4);

    // ---------------- backpressure ----------------
    do_reset();
    push(2'b01, 5'd3);
    p_valid = 2'b01; p_rd = {5'd0, 5'd3}; p_data = {32'h0, 32'hCAFE_F00D};
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 32'hCAFE_F00D);
      check("bp_p_ready", p_ready, 0);
      check("bp_outstanding", outstanding, 1);
      tick();
    end

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 3; i++) push(2'b10, 5'(i + 4));
    #1;
    check("mid_before", outstanding, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_outstanding", outstanding, 0);
    check("mid_rsp_valid", rsp_valid, 0);

    // ---------------- randomized vs reference model ----------------
    do_reset();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      int     k;
      int     ones;
      bit     full;
      bit     legal;
      bit     e_push;
      bit     e_pop;
      bit     e_valid;
      logic [1:0] e_qv;
      logic [1:0] e_pr;
      req_valid = ($urandom_range(0, 3) != 0);
      req_sel   = 2'($urandom_range(0, 7) == 0 ? $urandom_range(0, 3)
                                               : ($urandom_range(0, 1) ? 1 : 2));
      req_instr = $urandom;
      req_rs    = {$urandom, $urandom, $urandom};
      q_ready   = 2'($urandom_range(0, 3));
      p_valid   = 2'($urandom_range(0, 3));
      p_rd      = 10'($urandom);
      p_data    = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      ones = 0; k = 0;
      for (int i = 0; i < NA; i++) if (req_sel[i]) begin ones++; k = i; end
      legal  = (ones == 1);
      full   = (mq.size() == MO);
      e_qv   = (req_valid && legal && !full) ? req_sel : 2'b00;
      e_push = req_valid && !full && (!legal || q_ready[k]);
      e_pr   = 2'b00;
      if (mq.size() == 0) begin
        e_valid = 1'b0;
      end else if (mq[0].err) begin
        e_valid = 1'b1;
        check("rnd_rsp_rd_err", rsp_rd, mq[0].rd);
        check("rnd_rsp_data_err", rsp_data, 0);
      end else begin
        e_valid = p_valid[mq[0].idx];
        e_pr[mq[0].idx] = rsp_ready;
        if (e_valid) begin
          check("rnd_rsp_rd", rsp_rd, p_rd[mq[0].idx*5 +: 5]);
          check("rnd_rsp_data", rsp_data, p_data[mq[0].idx*DW +: DW]);
        end
      end
      e_pop = e_valid && rsp_ready;
      check("rnd_q_valid", q_valid, e_qv);
      check("rnd_req_ready", req_ready, e_push);
      check("rnd_q_instr", q_instr, req_valid ? req_instr : 32'h0);
      check("rnd_rsp_valid", rsp_valid, e_valid);
      check("rnd_rsp_error", rsp_error, (mq.size() != 0) && mq[0].err);
      check("rnd_p_ready", p_ready, e_pr);
      check("rnd_outstanding", outstanding, mq.size());
      tick();
      if (e_pop) void'(mq.pop_front());
      if (e_push) mq.push_back('{err: !legal, idx: k, rd: req_instr[11:7]});
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
